// File: rtl/pixel_draw_engine.sv
// pixel_draw_engine
//   Answers the game control FSM's draw requests. A draw_squares request
//   rasterises N_SQUARES falling squares, a draw_catcher request rasterises
//   the catcher bar. One pixel per cycle goes to the VGA adapter, and a
//   one-cycle finish pulse goes back to control.
//
// Optional feature (compile-time macro ERASE_PREV_EN):
//   When defined, each completed pass remembers its footprint. The next pass
//   for that object first repaints the old footprint in BG_COLOUR. The repaint
//   uses the same raster and clip rules as the draw pass. When the macro is
//   undefined, the erase path and its registers are not built.
//
// Ports
//   clock                  in   system clock, rising edge
//   reset                  in   asynchronous, active-low
//   draw_squares           in   request level for the squares pass
//   draw_catcher           in   request level for the catcher pass
//   square_x               in   packed top-left x; square i is [8i+7:8i]
//   square_y               in   packed top-left y; square i is [7i+6:7i]
//   catcher_x              in   catcher left x
//   x_out, y_out           out  pixel coordinates (truncated sums)
//   colour_out             out  pixel colour
//   pixel_valid            out  pixel write strobe (VGA writeEn)
//   finish_drawing_squares out  one-cycle done pulse
//   finish_drawing_catcher out  one-cycle done pulse
//   busy                   out  high whenever state is not IDLE
//
// Handshake: a request is a level. Control raises it and holds it until it
// sees the matching finish pulse. The engine samples the request on every
// edge and starts a pass from IDLE. Dropping the request mid-pass aborts the
// pass without a finish pulse. After a finish pulse, the engine waits in
// WAIT_LOW until both requests are low, so a held request cannot start a
// second pass.
module pixel_draw_engine #(
  parameter int         N_SQUARES      = 4,
  parameter int         SQ_SIZE        = 4,
  parameter int         CATCHER_W      = 16,
  parameter int         CATCHER_H      = 2,
  parameter int         CATCHER_Y      = 112,
  parameter int         SCREEN_W       = 160,
  parameter int         SCREEN_H       = 120,
  parameter logic [2:0] SQ_COLOUR      = 3'b100,
  parameter logic [2:0] CATCHER_COLOUR = 3'b111,
  parameter logic [2:0] BG_COLOUR      = 3'b000
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   draw_squares,
  input  logic                   draw_catcher,
  input  logic [8*N_SQUARES-1:0] square_x,
  input  logic [7*N_SQUARES-1:0] square_y,
  input  logic [7:0]             catcher_x,
  output logic [7:0]             x_out,
  output logic [6:0]             y_out,
  output logic [2:0]             colour_out,
  output logic                   pixel_valid,
  output logic                   finish_drawing_squares,
  output logic                   finish_drawing_catcher,
  output logic                   busy
);

  localparam int IDX_W = (N_SQUARES > 1) ? $clog2(N_SQUARES) : 1;

  localparam logic [7:0]       SQ_LAST_X = 8'(SQ_SIZE - 1);
  localparam logic [6:0]       SQ_LAST_Y = 7'(SQ_SIZE - 1);
  localparam logic [7:0]       CT_LAST_X = 8'(CATCHER_W - 1);
  localparam logic [6:0]       CT_LAST_Y = 7'(CATCHER_H - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_SQUARES - 1);
  localparam logic [6:0]       CT_Y      = 7'(CATCHER_Y);
  localparam logic [8:0]       SCR_W     = 9'(SCREEN_W);
  localparam logic [7:0]       SCR_H     = 8'(SCREEN_H);

  typedef enum logic [2:0] {
    IDLE, SQ_ERASE, SQ_DRAW, SQ_DONE, CT_ERASE, CT_DRAW, CT_DONE, WAIT_LOW
  } state_t;

  state_t state, next_state;

  // Raster position inside the current object, and the current square index.
  logic [7:0]       ox;
  logic [6:0]       oy;
  logic [IDX_W-1:0] idx;

  // Positions captured on the IDLE exit edge.
  logic [7:0] snap_sx [N_SQUARES];
  logic [6:0] snap_sy [N_SQUARES];
  logic [7:0] snap_cx;

`ifdef ERASE_PREV_EN
  logic [7:0] prev_sx [N_SQUARES];
  logic [6:0] prev_sy [N_SQUARES];
  logic [7:0] prev_cx;
  logic       prev_sq_valid;
  logic       prev_ct_valid;
`endif

  // Per-state pixel source selection.
  logic       in_pass;
  logic       is_sq;
  logic [7:0] base_x;
  logic [6:0] base_y;
  logic [2:0] pass_colour;
  logic [8:0] sum_x;
  logic [7:0] sum_y;
  logic       col_last, row_last, pass_last, active_req;

  always_comb begin
    in_pass     = 1'b0;
    is_sq       = 1'b0;
    base_x      = '0;
    base_y      = '0;
    pass_colour = '0;
    case (state)
      SQ_DRAW: begin
        in_pass     = 1'b1;
        is_sq       = 1'b1;
        base_x      = snap_sx[idx];
        base_y      = snap_sy[idx];
        pass_colour = SQ_COLOUR;
      end
      CT_DRAW: begin
        in_pass     = 1'b1;
        base_x      = snap_cx;
        base_y      = CT_Y;
        pass_colour = CATCHER_COLOUR;
      end
`ifdef ERASE_PREV_EN
      SQ_ERASE: begin
        in_pass     = 1'b1;
        is_sq       = 1'b1;
        base_x      = prev_sx[idx];
        base_y      = prev_sy[idx];
        pass_colour = BG_COLOUR;
      end
      CT_ERASE: begin
        in_pass     = 1'b1;
        base_x      = prev_cx;
        base_y      = CT_Y;
        pass_colour = BG_COLOUR;
      end
`endif
      default: ;
    endcase
  end

  // Sums are one bit wider than the outputs. Off-screen pixels are therefore
  // clipped instead of wrapping back onto the screen.
  assign sum_x      = {1'b0, base_x} + {1'b0, ox};
  assign sum_y      = {1'b0, base_y} + {1'b0, oy};
  assign col_last   = is_sq ? (ox == SQ_LAST_X) : (ox == CT_LAST_X);
  assign row_last   = is_sq ? (oy == SQ_LAST_Y) : (oy == CT_LAST_Y);
  assign pass_last  = col_last && row_last && (!is_sq || (idx == IDX_LAST));
  assign active_req = is_sq ? draw_squares : draw_catcher;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (draw_squares) begin
`ifdef ERASE_PREV_EN
          next_state = prev_sq_valid ? SQ_ERASE : SQ_DRAW;
`else
          next_state = SQ_DRAW;
`endif
        end else if (draw_catcher) begin
`ifdef ERASE_PREV_EN
          next_state = prev_ct_valid ? CT_ERASE : CT_DRAW;
`else
          next_state = CT_DRAW;
`endif
        end
      end
      SQ_ERASE, SQ_DRAW, CT_ERASE, CT_DRAW: begin
        if (!active_req) begin
          next_state = IDLE;
        end else if (pass_last) begin
          case (state)
            SQ_ERASE: next_state = SQ_DRAW;
            SQ_DRAW:  next_state = SQ_DONE;
            CT_ERASE: next_state = CT_DRAW;
            default:  next_state = CT_DONE;
          endcase
        end
      end
      SQ_DONE, CT_DONE: next_state = WAIT_LOW;
      WAIT_LOW: if (!draw_squares && !draw_catcher) next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // The counters advance only while the pass continues. Any state change
  // clears them, so each pass and each erase-to-draw hand-off starts at
  // pixel 0.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ox  <= '0;
      oy  <= '0;
      idx <= '0;
    end else if (in_pass && (next_state == state)) begin
      if (col_last) begin
        ox <= '0;
        if (row_last) begin
          oy  <= '0;
          idx <= idx + IDX_W'(1);
        end else begin
          oy <= oy + 7'd1;
        end
      end else begin
        ox <= ox + 8'd1;
      end
    end else begin
      ox  <= '0;
      oy  <= '0;
      idx <= '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_SQUARES; i++) begin
        snap_sx[i] <= '0;
        snap_sy[i] <= '0;
      end
      snap_cx <= '0;
    end else if (state == IDLE && (draw_squares || draw_catcher)) begin
      for (int i = 0; i < N_SQUARES; i++) begin
        snap_sx[i] <= square_x[8*i +: 8];
        snap_sy[i] <= square_y[7*i +: 7];
      end
      snap_cx <= catcher_x;
    end
  end

`ifdef ERASE_PREV_EN
  // Only a completed pass updates the remembered footprint. An aborted pass
  // never painted its full footprint.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_SQUARES; i++) begin
        prev_sx[i] <= '0;
        prev_sy[i] <= '0;
      end
      prev_cx       <= '0;
      prev_sq_valid <= 1'b0;
      prev_ct_valid <= 1'b0;
    end else if (state == SQ_DONE) begin
      for (int i = 0; i < N_SQUARES; i++) begin
        prev_sx[i] <= snap_sx[i];
        prev_sy[i] <= snap_sy[i];
      end
      prev_sq_valid <= 1'b1;
    end else if (state == CT_DONE) begin
      prev_cx       <= snap_cx;
      prev_ct_valid <= 1'b1;
    end
  end
`endif

  assign x_out                  = in_pass ? sum_x[7:0] : '0;
  assign y_out                  = in_pass ? sum_y[6:0] : '0;
  assign colour_out             = in_pass ? pass_colour : '0;
  assign pixel_valid            = in_pass && (sum_x < SCR_W) && (sum_y < SCR_H);
  assign finish_drawing_squares = (state == SQ_DONE);
  assign finish_drawing_catcher = (state == CT_DONE);
  assign busy                   = (state != IDLE);

endmodule

// File: tb/tb_pixel_draw_engine.sv
// Testbench for pixel_draw_engine. The reference model lists every cycle of
// a pass as {valid, x, y, colour}. It builds that list from the
// object rectangles in raster order, and clips each pixel against the
// screen size. Compile with ERASE_PREV_EN to match an erase-enabled build.
module tb_pixel_draw_engine;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        draw_squares = 1'b0;
  logic        draw_catcher = 1'b0;
  logic [31:0] square_x = '0;
  logic [27:0] square_y = '0;
  logic [7:0]  catcher_x = '0;
  logic [7:0]  x_out;
  logic [6:0]  y_out;
  logic [2:0]  colour_out;
  logic        pixel_valid, finish_drawing_squares, finish_drawing_catcher, busy;

  pixel_draw_engine dut (
    .clock(clock), .reset(reset),
    .draw_squares(draw_squares), .draw_catcher(draw_catcher),
    .square_x(square_x), .square_y(square_y), .catcher_x(catcher_x),
    .x_out(x_out), .y_out(y_out), .colour_out(colour_out),
    .pixel_valid(pixel_valid),
    .finish_drawing_squares(finish_drawing_squares),
    .finish_drawing_catcher(finish_drawing_catcher),
    .busy(busy)
  );

  // clock / reset
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // scoreboard: expected {valid, x, y, colour}
  // observed adds {fin_sq, fin_ct, busy} on top
  logic [18:0] exp_q[$];
  logic [21:0] obs_q[$];

  // model memory of the last completed pass per object
  logic [31:0] m_prev_sx = '0;
  logic [27:0] m_prev_sy = '0;
  logic [7:0]  m_prev_cx = '0;
  bit          m_prev_sq_v = 1'b0;
  bit          m_prev_ct_v = 1'b0;

  function automatic logic [18:0] pix_of(input logic [21:0] o);
    pix_of = {o[18], o[17:3], (o[18] ? o[2:0] : 3'b000)};
  endfunction

  task automatic push_rect(input int bx, input int by, input int w, input int h,
                           input logic [2:0] col);
    for (int oy = 0; oy < h; oy++) begin
      for (int ox = 0; ox < w; ox++) begin
        int xs;
        int ys;
        bit v;
        xs = bx + ox;
        ys = by + oy;
        v  = (xs < 160) && (ys < 120);
        exp_q.push_back({v, xs[7:0], ys[6:0], (v ? col : 3'b000)});
      end
    end
  endtask

  task automatic model_squares(input logic [31:0] sx, input logic [27:0] sy);
    exp_q.delete();
`ifdef ERASE_PREV_EN
    if (m_prev_sq_v)
      for (int i = 0; i < 4; i++)
        push_rect(int'(m_prev_sx[8*i +: 8]), int'(m_prev_sy[7*i +: 7]), 4, 4, 3'b000);
`endif
    for (int i = 0; i < 4; i++)
      push_rect(int'(sx[8*i +: 8]), int'(sy[7*i +: 7]), 4, 4, 3'b100);
  endtask

  task automatic model_catcher(input logic [7:0] cx);
    exp_q.delete();
`ifdef ERASE_PREV_EN
    if (m_prev_ct_v) push_rect(int'(m_prev_cx), 112, 16, 2, 3'b000);
`endif
    push_rect(int'(cx), 112, 16, 2, 3'b111);
  endtask

  // driver: raise the request(s) and record n pass cycles plus the done cycle.
  // Inputs are scrambled once the pass has started, so the snapshot is tested too.
  task automatic run_request(input bit sq, input bit ct, input int n);
    obs_q.delete();
    @(negedge clock);
    draw_squares = sq;
    draw_catcher = ct;
    for (int i = 0; i <= n; i++) begin
      @(negedge clock);
      obs_q.push_back({finish_drawing_squares, finish_drawing_catcher, busy,
                       pixel_valid, x_out, y_out, colour_out});
      if (i == 0) begin
        square_x  = $urandom;
        square_y  = 28'($urandom);
        catcher_x = 8'($urandom);
      end
    end
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if ({busy, pixel_valid, finish_drawing_squares, finish_drawing_catcher, x_out, y_out, colour_out} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b valid=%b x=%0d y=%0d col=%b, want all 0",
               busy, pixel_valid, x_out, y_out, colour_out);
    end
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    checks++;
    if (busy !== 1'b0 || pixel_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got busy=%b valid=%b, want 0 0", busy, pixel_valid);
    end
  endtask

  task automatic test_squares_basic;
    logic [31:0] sx;
    logic [27:0] sy;
    int n;
    int d;
    sx = {8'd120, 8'd80, 8'd40, 8'd10};
    sy = {7'd100, 7'd50, 7'd0, 7'd20};
    model_squares(sx, sy);
    n = exp_q.size();
    d = n - 64;
    square_x = sx;
    square_y = sy;
    run_request(1'b1, 1'b0, n);
    for (int i = 0; i < n; i++) begin
      checks++;
      if ({obs_q[i][21:19], pix_of(obs_q[i])} !== {3'b001, exp_q[i]}) begin
        errors++;
        $display("FAIL sq_basic_pixel %0d: got %h want %h", i,
                 {obs_q[i][21:19], pix_of(obs_q[i])}, {3'b001, exp_q[i]});
      end
    end
    checks++;
    if (pix_of(obs_q[d]) !== {1'b1, 8'd10, 7'd20, 3'b100} ||
        pix_of(obs_q[d+4]) !== {1'b1, 8'd10, 7'd21, 3'b100} ||
        pix_of(obs_q[d+16]) !== {1'b1, 8'd40, 7'd0, 3'b100}) begin
      errors++;
      $display("FAIL sq_basic_landmarks: got %h %h %h want (10,20) (10,21) (40,0)",
               pix_of(obs_q[d]), pix_of(obs_q[d+4]), pix_of(obs_q[d+16]));
    end
    checks++;
    if (obs_q[n][21:18] !== 4'b1010) begin
      errors++;
      $display("FAIL sq_basic_finish: got fs,fc,busy,valid=%b want 1010", obs_q[n][21:18]);
    end
    draw_squares = 1'b0;
    @(negedge clock);
    checks++;
    if (finish_drawing_squares !== 1'b0) begin
      errors++;
      $display("FAIL sq_finish_width: got %b want 0 one cycle after pulse", finish_drawing_squares);
    end
    @(negedge clock);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL sq_basic_idle: got busy=%b want 0", busy);
    end
    m_prev_sx = sx;
    m_prev_sy = sy;
    m_prev_sq_v = 1'b1;
  endtask

  task automatic test_catcher;
    int n;
    catcher_x = 8'd50;
    model_catcher(8'd50);
    n = exp_q.size();
    run_request(1'b0, 1'b1, n);
    for (int i = 0; i < n; i++) begin
      checks++;
      if ({obs_q[i][21:19], pix_of(obs_q[i])} !== {3'b001, exp_q[i]}) begin
        errors++;
        $display("FAIL catcher_pixel %0d: got %h want %h", i,
                 {obs_q[i][21:19], pix_of(obs_q[i])}, {3'b001, exp_q[i]});
      end
    end
    checks++;
    if (obs_q[n][21:18] !== 4'b0110) begin
      errors++;
      $display("FAIL catcher_finish: got fs,fc,busy,valid=%b want 0110", obs_q[n][21:18]);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      checks++;
      if ({finish_drawing_catcher, busy, pixel_valid} !== 3'b010) begin
        errors++;
        $display("FAIL catcher_held %0d: got fc,busy,valid=%b want 010", i,
                 {finish_drawing_catcher, busy, pixel_valid});
      end
    end
    draw_catcher = 1'b0;
    @(negedge clock);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL catcher_release: got busy=%b want 0", busy);
    end
    m_prev_cx = 8'd50;
    m_prev_ct_v = 1'b1;
  endtask

  task automatic test_clip;
    logic [31:0] sx;
    logic [27:0] sy;
    int n;
    int nv;
    sx = {8'd120, 8'd80, 8'd40, 8'd158};
    sy = {7'd100, 7'd50, 7'd0, 7'd118};
    model_squares(sx, sy);
    n = exp_q.size();
    square_x = sx;
    square_y = sy;
    run_request(1'b1, 1'b0, n);
    nv = 0;
    for (int i = 0; i < n; i++) begin
      checks++;
      if ({obs_q[i][21:19], pix_of(obs_q[i])} !== {3'b001, exp_q[i]}) begin
        errors++;
        $display("FAIL clip_pixel %0d: got %h want %h", i,
                 {obs_q[i][21:19], pix_of(obs_q[i])}, {3'b001, exp_q[i]});
      end
      if (i >= n - 64 && obs_q[i][18]) nv++;
    end
    checks++;
    if (nv != 52) begin
      errors++;
      $display("FAIL clip_count: got %0d valid draw pixels want 52", nv);
    end
    checks++;
    if (obs_q[n][21:18] !== 4'b1010) begin
      errors++;
      $display("FAIL clip_finish: got fs,fc,busy,valid=%b want 1010 after 64 draw cycles", obs_q[n][21:18]);
    end
    draw_squares = 1'b0;
    repeat (2) @(negedge clock);
    m_prev_sx = sx;
    m_prev_sy = sy;
  endtask

  task automatic test_priority;
    logic [31:0] sx;
    logic [27:0] sy;
    logic [7:0] cx;
    int n;
    sx = $urandom;
    sy = 28'($urandom);
    cx = 8'd70;
    model_squares(sx, sy);
    n = exp_q.size();
    square_x = sx;
    square_y = sy;
    catcher_x = cx;
    run_request(1'b1, 1'b1, n);
    for (int i = 0; i < n; i++) begin
      checks++;
      if ({obs_q[i][21:19], pix_of(obs_q[i])} !== {3'b001, exp_q[i]}) begin
        errors++;
        $display("FAIL prio_sq_pixel %0d: got %h want %h", i,
                 {obs_q[i][21:19], pix_of(obs_q[i])}, {3'b001, exp_q[i]});
      end
    end
    checks++;
    if (obs_q[n][21:18] !== 4'b1010) begin
      errors++;
      $display("FAIL prio_sq_finish: got fs,fc,busy,valid=%b want 1010", obs_q[n][21:18]);
    end
    m_prev_sx = sx;
    m_prev_sy = sy;
    draw_squares = 1'b0;
    repeat (3) begin
      @(negedge clock);
      checks++;
      if ({busy, pixel_valid} !== 2'b10) begin
        errors++;
        $display("FAIL prio_wait_low: got busy,valid=%b want 10 while catcher held", {busy, pixel_valid});
      end
    end
    draw_catcher = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL prio_idle: got busy=%b want 0", busy);
    end
    catcher_x = cx;
    model_catcher(cx);
    n = exp_q.size();
    run_request(1'b0, 1'b1, n);
    for (int i = 0; i < n; i++) begin
      checks++;
      if ({obs_q[i][21:19], pix_of(obs_q[i])} !== {3'b001, exp_q[i]}) begin
        errors++;
        $display("FAIL prio_ct_pixel %0d: got %h want %h", i,
                 {obs_q[i][21:19], pix_of(obs_q[i])}, {3'b001, exp_q[i]});
      end
    end
    checks++;
    if (obs_q[n][21:18] !== 4'b0110) begin
      errors++;
      $display("FAIL prio_ct_finish: got fs,fc,busy,valid=%b want 0110", obs_q[n][21:18]);
    end
    draw_catcher = 1'b0;
    repeat (2) @(negedge clock);
    m_prev_cx = cx;
  endtask

  task automatic test_abort_and_reset;
    logic [31:0] sx;
    logic [27:0] sy;
    sx = {8'd5, 8'd60, 8'd90, 8'd30};
    sy = {7'd3, 7'd40, 7'd70, 7'd10};
    model_squares(sx, sy);
    square_x = sx;
    square_y = sy;
    @(negedge clock);
    draw_squares = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      checks++;
      if ({busy, pixel_valid, x_out, y_out, colour_out} !== {1'b1, exp_q[i]}) begin
        errors++;
        $display("FAIL abort_pixel %0d: got %h want %h", i,
                 {busy, pixel_valid, x_out, y_out, colour_out}, {1'b1, exp_q[i]});
      end
    end
    draw_squares = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      checks++;
      if ({busy, pixel_valid, finish_drawing_squares} !== 3'b000) begin
        errors++;
        $display("FAIL abort_idle %0d: got busy,valid,fs=%b want 000", i,
                 {busy, pixel_valid, finish_drawing_squares});
      end
    end
    catcher_x = 8'd30;
    @(negedge clock);
    draw_catcher = 1'b1;
    repeat (5) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({busy, pixel_valid, finish_drawing_squares, finish_drawing_catcher, x_out, y_out, colour_out} !== '0) begin
      errors++;
      $display("FAIL reset_midpass: got busy=%b valid=%b x=%0d y=%0d col=%b want all 0",
               busy, pixel_valid, x_out, y_out, colour_out);
    end
    draw_catcher = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    m_prev_sq_v = 1'b0;
    m_prev_ct_v = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checks++;
      if ({busy, pixel_valid} !== 2'b00) begin
        errors++;
        $display("FAIL reset_no_resume %0d: got busy,valid=%b want 00", i, {busy, pixel_valid});
      end
    end
  endtask

  task automatic test_erase_move;
    logic [31:0] sx;
    logic [27:0] sy;
    int n;
    sx = {8'd100, 8'd70, 8'd25, 8'd3};
    sy = {7'd60, 7'd33, 7'd9, 7'd1};
    for (int pass = 0; pass < 2; pass++) begin
      model_squares(sx, sy);
      n = exp_q.size();
      square_x = sx;
      square_y = sy;
      run_request(1'b1, 1'b0, n);
      for (int i = 0; i < n; i++) begin
        checks++;
        if ({obs_q[i][21:19], pix_of(obs_q[i])} !== {3'b001, exp_q[i]}) begin
          errors++;
          $display("FAIL move_pixel p%0d %0d: got %h want %h", pass, i,
                   {obs_q[i][21:19], pix_of(obs_q[i])}, {3'b001, exp_q[i]});
        end
      end
      checks++;
      if (obs_q[n][21:18] !== 4'b1010) begin
        errors++;
        $display("FAIL move_finish p%0d: got fs,fc,busy,valid=%b want 1010", pass, obs_q[n][21:18]);
      end
      draw_squares = 1'b0;
      repeat (2) @(negedge clock);
      m_prev_sx = sx;
      m_prev_sy = sy;
      m_prev_sq_v = 1'b1;
      for (int i = 0; i < 4; i++) sy[7*i +: 7] = sy[7*i +: 7] + 7'd1;
    end
  endtask

  task automatic test_random;
    logic [31:0] sx;
    logic [27:0] sy;
    logic [7:0] cx;
    int n;
    for (int it = 0; it < 6; it++) begin
      sx = $urandom;
      for (int i = 0; i < 4; i++) sy[7*i +: 7] = 7'($urandom_range(0, 127));
      model_squares(sx, sy);
      n = exp_q.size();
      square_x = sx;
      square_y = sy;
      run_request(1'b1, 1'b0, n);
      for (int i = 0; i < n; i++) begin
        checks++;
        if ({obs_q[i][21:19], pix_of(obs_q[i])} !== {3'b001, exp_q[i]}) begin
          errors++;
          $display("FAIL rand_sq it%0d %0d: got %h want %h", it, i,
                   {obs_q[i][21:19], pix_of(obs_q[i])}, {3'b001, exp_q[i]});
        end
      end
      checks++;
      if (obs_q[n][21:18] !== 4'b1010) begin
        errors++;
        $display("FAIL rand_sq_finish it%0d: got %b want 1010", it, obs_q[n][21:18]);
      end
      draw_squares = 1'b0;
      repeat (2) @(negedge clock);
      m_prev_sx = sx;
      m_prev_sy = sy;
      m_prev_sq_v = 1'b1;

      cx = 8'($urandom_range(0, 255));
      model_catcher(cx);
      n = exp_q.size();
      catcher_x = cx;
      run_request(1'b0, 1'b1, n);
      for (int i = 0; i < n; i++) begin
        checks++;
        if ({obs_q[i][21:19], pix_of(obs_q[i])} !== {3'b001, exp_q[i]}) begin
          errors++;
          $display("FAIL rand_ct it%0d %0d: got %h want %h", it, i,
                   {obs_q[i][21:19], pix_of(obs_q[i])}, {3'b001, exp_q[i]});
        end
      end
      checks++;
      if (obs_q[n][21:18] !== 4'b0110) begin
        errors++;
        $display("FAIL rand_ct_finish it%0d: got %b want 0110", it, obs_q[n][21:18]);
      end
      draw_catcher = 1'b0;
      repeat (2) @(negedge clock);
      m_prev_cx = cx;
      m_prev_ct_v = 1'b1;
    end
  endtask

  initial begin
    test_reset();
    test_squares_basic();
    test_catcher();
    test_clip();
    test_priority();
    test_abort_and_reset();
    test_erase_move();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
